// File: rtl/lvdc_interrupt_controller.sv
// lvdc_interrupt_controller
//
// Interrupt front-end for the LVDC virtual backplane. Asynchronous sources
// are synchronized and their rising edges are latched as sticky pending bits.
// The lowest-index unmasked pending source is signalled on keyrupt. The
// controller then waits for the computer's service acknowledge. Nothing is
// accepted until the computer reports booted.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no interrupt in flight; waiting for an eligible pending bit
// ST_FIRE     | keyrupt high for PULSE_LEN cycles, vector latched
// ST_WAIT_ACK | waiting for ack; re-fires same vector after ACK_TIMEOUT
// ST_HOLDOFF  | quiet period of HOLDOFF cycles after an accepted ack

module lvdc_interrupt_controller #(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int HOLDOFF     = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             booted,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             ack,
    output logic             keyrupt,
    output logic [3:0]       vector,
    output logic [N_IRQ-1:0] pending,
    output logic             irq_active
);

    // One shared down-counter serves pulse width, ack timeout and holdoff;
    // 16 bits covers the largest ACK_TIMEOUT.
    localparam int CW = 16;

    localparam logic [CW-1:0] PULSE_M1   = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] TIMEOUT_M1 = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_M1    = CW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRE     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        vector_q, vector_d;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  mask_q;
    logic              keyrupt_q, keyrupt_d;
    logic              active_q, active_d;

    logic [N_IRQ-1:0]  sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0]  prev_q;
    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  eligible;
    logic [3:0]        winner;
    logic              ack_ok;

    // Synchronizer chain plus one delayed copy of the last stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Mask register; a written mask is seen by arbitration from the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= mask_wdata;
        end
    end

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        eligible = pending_q & ~mask_q;
        winner   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 4'(i);
            end
        end
    end

    // Next state, counter and vector. Losing booted overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vector_d = vector_q;
        ack_ok   = 1'b0;
        if (!booted) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|eligible) begin
                        state_d  = ST_FIRE;
                        cnt_d    = PULSE_M1;
                        vector_d = winner;
                    end
                end
                ST_FIRE: begin
                    // ack is deliberately ignored here
                    if (cnt_q == '0) begin
                        state_d = ST_WAIT_ACK;
                        cnt_d   = TIMEOUT_M1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack) begin
                        ack_ok = 1'b1;
                        if (HOLDOFF == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = HOLD_M1;
                        end
                    end else if (cnt_q == '0) begin
                        // re-fire the same vector; it is still pending
                        state_d = ST_FIRE;
                        cnt_d   = PULSE_M1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        keyrupt_d = (state_d == ST_FIRE);
        active_d  = (state_d == ST_FIRE) || (state_d == ST_WAIT_ACK);
    end

    // Pending update: ack clears the serviced bit, then a fresh edge re-sets it.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_IRQ; i++) begin
            if (ack_ok && (vector_q == 4'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
        pending_d = pending_d | rise;
        if (!booted) begin
            pending_d = '0;
        end
    end

    // FSM, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            vector_q  <= '0;
            pending_q <= '0;
            keyrupt_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vector_q  <= vector_d;
            pending_q <= pending_d;
            keyrupt_q <= keyrupt_d;
            active_q  <= active_d;
        end
    end

    assign keyrupt    = keyrupt_q;
    assign vector     = vector_q;
    assign pending    = pending_q;
    assign irq_active = active_q;

endmodule

// File: doc/lvdc_interrupt_controller.md
# lvdc_interrupt_controller

Upstream interrupt front-end for the LVDC `virtual_backplane`: it collects asynchronous external interrupt sources, latches their rising edges as sticky pending bits, and drives the computer's single `keyrupt` input. It arbitrates by fixed priority, one interrupt at a time, and waits for a service acknowledge from the computer. No interrupt is accepted before the computer reports `booted`. It replaces ad-hoc `keyrupt` generation in benches and on the backplane.

## Interface
Parameters:
- `N_IRQ`, 8: number of interrupt sources (1..16).
- `SYNC_STAGES`, 2: synchronizer flops per source (≥2).
- `PULSE_LEN`, 1: cycles `keyrupt` is held high per firing (1..15).
- `HOLDOFF`, 16: minimum idle cycles after an ack before the next firing (0..255).
- `ACK_TIMEOUT`, 256: cycles to wait for `ack` before re-firing the same vector (2..65535).

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `booted`  in  1  computer boot-complete flag.
- `irq_in`  in  N_IRQ  asynchronous interrupt requests; the rising edge requests.
- `mask_we`  in  1  loads `mask_wdata` into the mask register.
- `mask_wdata`  in  N_IRQ  mask value; 1 = source disabled.
- `ack`  in  1  one-cycle pulse; the computer has entered service for `vector`.
- `keyrupt`  out  1  interrupt strobe to the computer.
- `vector`  out  4  index of the interrupt being signalled or serviced.
- `pending`  out  N_IRQ  sticky pending bits.
- `irq_active`  out  1  high from firing until ack.

## Operation
- Synchronizer: each `irq_in` bit passes through `SYNC_STAGES` flops. An edge detector compares the last stage with a delayed copy.
- Pending: a synchronized rising edge sets `pending[i]` regardless of mask. Masked bits latch but never fire.
- Clearing: `pending[vector]` is cleared only on an accepted `ack`.
- Same-cycle clear and new edge on the same bit: the set wins and the bit stays pending.
- While `booted`=0, edges are discarded, `pending` is forced to 0, and the FSM stays in IDLE.
- Mask: `mask_we` takes effect on the next edge. Masking the current `vector` in FIRE or WAIT_ACK does not cancel the in-flight interrupt.
- Priority: the lowest index among `pending & ~mask` wins. The winner is latched into `vector` on leaving IDLE.
- FSM states:
  - IDLE → FIRE when `booted` && |(`pending & ~mask`).
  - FIRE: `keyrupt`=1 for `PULSE_LEN` cycles, then → WAIT_ACK.
  - WAIT_ACK: on `ack`, clear `pending[vector]` and → HOLDOFF. If `ACK_TIMEOUT` cycles pass without `ack`, → FIRE again with the same `vector`.
  - HOLDOFF: count `HOLDOFF` cycles, then → IDLE. `HOLDOFF`=0 goes straight to IDLE on the next edge.
- Acks outside WAIT_ACK are ignored, including an `ack` during FIRE.
- `irq_active` = state ∈ {FIRE, WAIT_ACK}.
- `booted` falling in any state: the FSM returns to IDLE on the next edge, `keyrupt` drops, and `pending` clears.

## Timing
- Reset values: `keyrupt`=0, `vector`=0, `pending`=0, `irq_active`=0. Mask=0 (all enabled), synchronizers=0, FSM=IDLE.
- Latency: an `irq_in` rising edge first sampled at clock edge k sets `pending` after edge k+`SYNC_STAGES`. `keyrupt` rises after edge k+`SYNC_STAGES`+1. With defaults this is 3 cycles.
- `keyrupt` is registered and glitch-free. It is high for exactly `PULSE_LEN` cycles per firing.
- Minimum spacing between firings for back-to-back sources: `PULSE_LEN` + ack delay + `HOLDOFF` + 1 (IDLE) cycles.
- An `irq_in` pulse shorter than one clock period may be missed. Sources must hold their level ≥2 cycles.
- A re-edge on an already-pending bit is absorbed; there is no counting.

## Test plan
- Boot gating: `booted`=0, pulse `irq_in[3]` → `pending`=0, `keyrupt` never rises. Then `booted`=1, pulse `irq_in[3]` (held 4 cycles) → `keyrupt` high 3 cycles after the first sampling edge, `vector`=3, for 1 cycle.
- Priority and holdoff: raise `irq_in[5]` and `irq_in[2]` on the same cycle → first `vector`=2. `ack` → `pending`=0x20. The next `keyrupt` fires exactly `HOLDOFF`+1 cycles after the ack edge, with `vector`=5.
- Mask: `mask_wdata`=0x01, edge on bit 0 → `pending[0]`=1, no `keyrupt`. Write mask 0 → `keyrupt` fires on the edge after next, with `vector`=0.
- Timeout: fire `vector`=1 and withhold `ack` → `keyrupt` re-pulses every `ACK_TIMEOUT`+`PULSE_LEN` cycles with `vector`=1. `ack` then clears `pending[1]`.
- Collision and reset: a new edge on bit 4 arriving in the same cycle as the `ack` for `vector`=4 → `pending[4]` stays 1 and re-fires after holdoff. Assert `rst` mid-FIRE → all outputs 0 immediately, without waiting for `clk`.
